// File: rtl/dcpu16_mram.sv
// dcpu16_mram: memory responder shared by the CPU G-BUS (operand reads) and
// F-BUS (fetch and operand write-back). It owns one single-port 16-bit word
// array, arbitrates round-robin between the buses and answers each transfer
// with a one-cycle ack pulse.
// Optional feature macro: DCPU16_MRAM_GWR_EN lets the G-BUS write the array;
// without it G-BUS transfers are always reads.
module dcpu16_mram #(
    parameter int AW   = 16,
    parameter int WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] g_adr,
    input  logic        g_stb,
    input  logic        g_wre,
    input  logic [15:0] g_dto,
    output logic [15:0] g_dti,
    output logic        g_ack,
    input  logic [15:0] f_adr,
    input  logic        f_stb,
    input  logic        f_wre,
    input  logic [15:0] f_dto,
    output logic [15:0] f_dti,
    output logic        f_ack
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        last_f;
    logic        sel_f;

    logic [15:0] mem [0:(1 << AW) - 1];

    logic          any_req;
    logic          pick_f;
    logic          gr_stb;
    logic          enter_ack;
    logic          acc_f;
    logic          acc_wre;
    logic          g_wr;
    logic [AW-1:0] acc_idx;
    logic [15:0]   acc_dto;
    logic [15:0]   rd_data;

    // Round-robin pick: F wins a tie unless F was the last bus served
    assign any_req = f_stb | g_stb;
    assign pick_f  = f_stb & (~g_stb | ~last_f);
    assign gr_stb  = sel_f ? f_stb : g_stb;

`ifdef DCPU16_MRAM_GWR_EN
    assign g_wr = g_wre;
`else
    // G-BUS writes are not honoured in this build; the input is masked off
    assign g_wr = g_wre & 1'b0;
`endif

    // Select the bus whose transfer completes on this edge (IDLE grants
    // directly when there are no wait cycles, otherwise the held grant)
    assign acc_f   = (state == ST_IDLE) ? pick_f : sel_f;
    assign acc_wre = acc_f ? f_wre : g_wr;
    assign acc_dto = acc_f ? f_dto : g_dto;
    assign acc_idx = acc_f ? f_adr[AW-1:0] : g_adr[AW-1:0];
    assign rd_data = mem[acc_idx];

    // Decide whether the access happens on this edge (entry into ACK)
    always_comb begin
        enter_ack = 1'b0;
        case (state)
            ST_IDLE: enter_ack = any_req && (WAIT == 0);
            ST_WAIT: enter_ack = gr_stb && (cnt == 4'd1);
            default: enter_ack = 1'b0;
        endcase
    end

    // Array write port; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (enter_ack && acc_wre) begin
            mem[acc_idx] <= acc_dto;
        end
    end

    // Arbitration FSM with registered ack pulses and held read-data outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            last_f <= 1'b0;
            sel_f  <= 1'b0;
            g_ack  <= 1'b0;
            f_ack  <= 1'b0;
            g_dti  <= 16'h0000;
            f_dti  <= 16'h0000;
        end else begin
            g_ack <= 1'b0;
            f_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        sel_f  <= pick_f;
                        last_f <= pick_f;
                        cnt    <= 4'(WAIT);
                        if (WAIT == 0) begin
                            state <= ST_ACK;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!gr_stb) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state <= ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            if (enter_ack) begin
                if (acc_f) begin
                    f_ack <= 1'b1;
                    f_dti <= acc_wre ? acc_dto : rd_data;
                end else begin
                    g_ack <= 1'b1;
                    g_dti <= acc_wre ? acc_dto : rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcpu16_mram.sv
// tb_dcpu16_mram: directed bench for dcpu16_mram. One instance runs with no
// wait cycles, a second with three wait cycles. Expected values are worked
// out by hand from the transfer sequence below.
module tb_dcpu16_mram;

    localparam int F0 = 0;
    localparam int G0 = 1;
    localparam int F3 = 2;
    localparam int G3 = 3;

`ifdef DCPU16_MRAM_GWR_EN
    localparam logic [15:0] GWR_EXP = 16'h5555;
`else
    localparam logic [15:0] GWR_EXP = 16'h0777;
`endif

    logic clk = 1'b0;
    logic rst0, rst3;

    logic [15:0] f0_adr, f0_dto, f0_dti, g0_adr, g0_dto, g0_dti;
    logic        f0_stb, f0_wre, f0_ack, g0_stb, g0_wre, g0_ack;
    logic [15:0] f3_adr, f3_dto, f3_dti, g3_adr, g3_dto, g3_dti;
    logic        f3_stb, f3_wre, f3_ack, g3_stb, g3_wre, g3_ack;

    int checks = 0;
    int passes = 0;
    logic [15:0] rdata;
    logic        saw_ack;

    dcpu16_mram #(.AW(16), .WAIT(0)) dut0 (
        .clk(clk), .rst(rst0),
        .g_adr(g0_adr), .g_stb(g0_stb), .g_wre(g0_wre), .g_dto(g0_dto),
        .g_dti(g0_dti), .g_ack(g0_ack),
        .f_adr(f0_adr), .f_stb(f0_stb), .f_wre(f0_wre), .f_dto(f0_dto),
        .f_dti(f0_dti), .f_ack(f0_ack)
    );

    dcpu16_mram #(.AW(16), .WAIT(3)) dut3 (
        .clk(clk), .rst(rst3),
        .g_adr(g3_adr), .g_stb(g3_stb), .g_wre(g3_wre), .g_dto(g3_dto),
        .g_dti(g3_dti), .g_ack(g3_ack),
        .f_adr(f3_adr), .f_stb(f3_stb), .f_wre(f3_wre), .f_dto(f3_dto),
        .f_dti(f3_dti), .f_ack(f3_ack)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end of sequence, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_bus(input int bus, input logic stb, input logic [15:0] adr,
                           input logic wre, input logic [15:0] dto);
        case (bus)
            F0: begin f0_stb = stb; f0_adr = adr; f0_wre = wre; f0_dto = dto; end
            G0: begin g0_stb = stb; g0_adr = adr; g0_wre = wre; g0_dto = dto; end
            F3: begin f3_stb = stb; f3_adr = adr; f3_wre = wre; f3_dto = dto; end
            default: begin g3_stb = stb; g3_adr = adr; g3_wre = wre; g3_dto = dto; end
        endcase
    endtask

    task automatic drop(input int bus);
        case (bus)
            F0: f0_stb = 1'b0;
            G0: g0_stb = 1'b0;
            F3: f3_stb = 1'b0;
            default: g3_stb = 1'b0;
        endcase
    endtask

    function automatic logic get_ack(input int bus);
        case (bus)
            F0: return f0_ack;
            G0: return g0_ack;
            F3: return f3_ack;
            default: return g3_ack;
        endcase
    endfunction

    function automatic logic [15:0] get_dti(input int bus);
        case (bus)
            F0: return f0_dti;
            G0: return g0_dti;
            F3: return f3_dti;
            default: return g3_dti;
        endcase
    endfunction

    // One complete transfer with a bounded wait for the ack
    task automatic apply_stimulus(input int bus, input logic [15:0] adr, input logic wre,
                                  input logic [15:0] dto, output logic [15:0] data);
        logic got;
        got  = 1'b0;
        data = 16'h0000;
        set_bus(bus, 1'b1, adr, wre, dto);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (get_ack(bus)) begin
                got  = 1'b1;
                data = get_dti(bus);
            end
        end
        drop(bus);
        checks++;
        assert (got === 1'b1) passes++;
        else $error("[TB] FAIL xfer_ack bus%0d: observed no ack expected ack", bus);
    endtask

    initial begin
        $display("[TB] dcpu16_mram directed sequence");
        rst0 = 1'b1; rst3 = 1'b1;
        set_bus(F0, 1'b0, 16'h0, 1'b0, 16'h0);
        set_bus(G0, 1'b0, 16'h0, 1'b0, 16'h0);
        set_bus(F3, 1'b0, 16'h0, 1'b0, 16'h0);
        set_bus(G3, 1'b0, 16'h0, 1'b0, 16'h0);
        #2;
        rst0 = 1'b0; rst3 = 1'b0;
        #1;
        check_output("reset_g_ack", 16'(g0_ack), 16'h0);
        check_output("reset_f_ack", 16'(f0_ack), 16'h0);
        check_output("reset_g_dti", g0_dti, 16'h0000);
        check_output("reset_f_dti", f0_dti, 16'h0000);
        step(); step();
        rst0 = 1'b1; rst3 = 1'b1;

        // Contention right after reset: F (write) first, G (read same addr) two cycles later
        set_bus(F0, 1'b1, 16'h0040, 1'b1, 16'hAAAA);
        set_bus(G0, 1'b1, 16'h0040, 1'b0, 16'h0000);
        step();
        check_output("cont1_f_ack_c1", 16'(f0_ack), 16'h1);
        check_output("cont1_g_ack_c1", 16'(g0_ack), 16'h0);
        check_output("cont1_f_dti_c1", f0_dti, 16'hAAAA);
        drop(F0);
        step();
        check_output("cont1_g_ack_c2", 16'(g0_ack), 16'h0);
        step();
        check_output("cont1_g_ack_c3", 16'(g0_ack), 16'h1);
        check_output("cont1_f_ack_c3", 16'(f0_ack), 16'h0);
        check_output("cont1_g_dti_c3", g0_dti, 16'hAAAA);
        drop(G0);

        // F-only write leaves F as last grant, so the next tie goes to G
        step();
        apply_stimulus(F0, 16'h0010, 1'b1, 16'hBEEF, rdata);
        check_output("f_wr_beef_dti", rdata, 16'hBEEF);
        step();
        set_bus(G0, 1'b1, 16'h0010, 1'b0, 16'h0000);
        set_bus(F0, 1'b1, 16'h0040, 1'b0, 16'h0000);
        step();
        check_output("cont2_g_ack_c1", 16'(g0_ack), 16'h1);
        check_output("cont2_f_ack_c1", 16'(f0_ack), 16'h0);
        check_output("cont2_g_dti_c1", g0_dti, 16'hBEEF);
        drop(G0);
        step(); step();
        check_output("cont2_f_ack_c3", 16'(f0_ack), 16'h1);
        check_output("cont2_f_dti_c3", f0_dti, 16'hAAAA);
        drop(F0);

        // Single G read, exact latency and pulse width
        step();
        set_bus(G0, 1'b1, 16'h0010, 1'b0, 16'h0000);
        step();
        check_output("g_rd_ack_c1", 16'(g0_ack), 16'h1);
        check_output("g_rd_dti_c1", g0_dti, 16'hBEEF);
        drop(G0);
        step();
        check_output("g_rd_ack_c2", 16'(g0_ack), 16'h0);

        // F write then G read of the same address
        set_bus(F0, 1'b1, 16'h0020, 1'b1, 16'h1234);
        step();
        check_output("f_wr_ack", 16'(f0_ack), 16'h1);
        check_output("f_wr_dti", f0_dti, 16'h1234);
        drop(F0);
        step();
        apply_stimulus(G0, 16'h0020, 1'b0, 16'h0000, rdata);
        check_output("g_rd_after_f_wr", rdata, 16'h1234);

        // G-BUS write, honoured only when the feature macro is defined
        step();
        apply_stimulus(F0, 16'h0030, 1'b1, 16'h0777, rdata);
        step();
        apply_stimulus(G0, 16'h0030, 1'b1, 16'h5555, rdata);
        check_output("g_wr_dti", rdata, GWR_EXP);
        step();
        apply_stimulus(F0, 16'h0030, 1'b0, 16'h0000, rdata);
        check_output("f_rd_after_g_wr", rdata, GWR_EXP);

        // Outputs hold between acks
        step(); step(); step();
        check_output("g_dti_hold", g0_dti, GWR_EXP);
        check_output("f_dti_hold", f0_dti, GWR_EXP);

        // WAIT=3 instance: ack exactly four cycles after the request
        step();
        apply_stimulus(F3, 16'h0005, 1'b1, 16'h00C3, rdata);
        step();
        set_bus(G3, 1'b1, 16'h0005, 1'b0, 16'h0000);
        step(); step(); step();
        check_output("w3_g_ack_c3", 16'(g3_ack), 16'h0);
        step();
        check_output("w3_g_ack_c4", 16'(g3_ack), 16'h1);
        check_output("w3_g_dti_c4", g3_dti, 16'h00C3);
        drop(G3);
        step();
        check_output("w3_g_ack_c5", 16'(g3_ack), 16'h0);

        // Aborted F write: no ack, memory untouched
        set_bus(F3, 1'b1, 16'h0005, 1'b1, 16'h9999);
        saw_ack = 1'b0;
        step();
        saw_ack = saw_ack | f3_ack;
        step();
        saw_ack = saw_ack | f3_ack;
        drop(F3);
        for (int i = 0; i < 6; i++) begin
            step();
            saw_ack = saw_ack | f3_ack;
        end
        check_output("abort_f_no_ack", 16'(saw_ack), 16'h0);

        // Aborted G read: no ack
        set_bus(G3, 1'b1, 16'h0005, 1'b0, 16'h0000);
        saw_ack = 1'b0;
        step();
        saw_ack = saw_ack | g3_ack;
        step();
        saw_ack = saw_ack | g3_ack;
        drop(G3);
        for (int i = 0; i < 6; i++) begin
            step();
            saw_ack = saw_ack | g3_ack;
        end
        check_output("abort_g_no_ack", 16'(saw_ack), 16'h0);
        apply_stimulus(G3, 16'h0005, 1'b0, 16'h0000, rdata);
        check_output("abort_mem_unchanged", rdata, 16'h00C3);

        // Asynchronous reset in the middle of a waiting transfer
        step();
        set_bus(F3, 1'b1, 16'h0005, 1'b0, 16'h0000);
        step(); step();
        #2;
        rst3 = 1'b0;
        #1;
        check_output("midrst_f_ack", 16'(f3_ack), 16'h0);
        check_output("midrst_f_dti", f3_dti, 16'h0000);
        check_output("midrst_g_dti", g3_dti, 16'h0000);
        @(negedge clk);
        drop(F3);
        rst3 = 1'b1;
        step();
        apply_stimulus(F3, 16'h0005, 1'b0, 16'h0000, rdata);
        check_output("post_rst_f_rd", rdata, 16'h00C3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dcpu16_mram.md
# dcpu16_mram

Simplified-Wishbone memory responder serving both CPU buses: the G-BUS (operand/effective-address reads) and the F-BUS (instruction fetch and operand write-back). It owns a single-port 16-bit word array, arbitrates round-robin between the two buses, and returns data with a one-cycle `ack` pulse per transfer. It is the slave end of the CPU memory-bus stall scheme, where the CPU advances only when `stb` equals `ack` on both buses.

## Interface
- `AW`, 16: array address width; depth 2^AW words; address bits above `AW-1` ignored.
- `WAIT`, 0: extra wait cycles per transfer, 0..15.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `g_adr` in 16: G-BUS word address.
- `g_stb` in 1: G-BUS request; held until `g_ack`.
- `g_wre` in 1: G-BUS write enable; used only with `DCPU16_MRAM_GWR_EN`.
- `g_dto` in 16: G-BUS write data.
- `g_dti` out 16: G-BUS read data; valid while `g_ack`=1.
- `g_ack` out 1: G-BUS transfer done, one-cycle pulse.
- `f_adr` in 16: F-BUS word address.
- `f_stb` in 1: F-BUS request; held until `f_ack`.
- `f_wre` in 1: F-BUS write enable.
- `f_dto` in 16: F-BUS write data.
- `f_dti` out 16: F-BUS read data; valid while `f_ack`=1.
- `f_ack` out 1: F-BUS transfer done, one-cycle pulse.

## Operation
- Reset (`rst`=0, async): FSM=IDLE, `g_ack`=`f_ack`=0, `g_dti`=`f_dti`=0, wait counter=0, last-grant=G. Array contents are not reset.
- FSM states:
  - IDLE: sample both `stb` inputs.
    - If none is high, stay in IDLE.
    - If exactly one is high, grant that bus.
    - If both are high, grant the bus opposite last-grant. After reset, F wins first.
    - On grant, update last-grant, load counter with `WAIT`, and go to WAIT if `WAIT`>0, else to ACK.
  - WAIT: decrement counter each cycle. At 1, go to ACK. If the granted `stb` drops, abort to IDLE with no access and no ack.
  - ACK: the granted `ack` is high for exactly this cycle. The access is performed on entry to ACK:
    - Read: `dti` ← mem[`adr[AW-1:0]`].
    - Write: mem ← `dto`; `dti` returns the written value.
    - Next state is always IDLE.
- Granted bus `adr`/`wre`/`dto` are sampled on the edge entering ACK; the requester holds them stable until ack.
- Non-granted bus waits: its `ack` stays 0 and its `dti` holds its last value.
- `dti` outputs hold their value between acks.
- Never assert both acks in the same cycle. Never assert `ack` while the matching `stb` is 0.

## Timing
- `stb` sampled high in IDLE at edge N → `ack`=1 during cycle N+1+`WAIT` → `ack`=0 during cycle N+2+`WAIT`.
- Back-to-back throughput: one transfer per 2+`WAIT` cycles. A `stb` still high in the ACK cycle belongs to the finished transfer and is re-sampled in IDLE.
- Contended pair (both `stb` high, WAIT=0): first ack at N+1, second at N+3.
- Write-then-read to the same address from the other bus returns the new data.

## Configuration
- `DCPU16_MRAM_GWR_EN` defined: G-BUS writes are honoured exactly like F-BUS writes.
- Undefined: `g_wre` is ignored, G-BUS transfers are always reads, and `g_dto` is unused.

## Test plan
- G read, WAIT=0, mem[0x0010]=0xBEEF: `g_stb`=1 with `g_adr`=0x0010 at cycle 0 → `g_ack`=1 and `g_dti`=0xBEEF in cycle 1, `g_ack`=0 in cycle 2.
- F write then G read: F writes 0x1234 to 0x0020; G then reads 0x0020 → `g_dti`=0x1234. `f_dti` shows 0x1234 at `f_ack`.
- Contention after reset, WAIT=0: both `stb` high at cycle 0 → `f_ack` at 1, `g_ack` at 3. Repeat with both high → G first, then F.
- WAIT=3: G read → `g_ack` exactly at cycle 4 and single-cycle. Drop `g_stb` at cycle 2 → no ack, memory unchanged, FSM returns to IDLE.
- Reset mid-transfer: `rst`=0 asynchronously during WAIT → `g_ack`/`f_ack`/`dti` go 0 immediately. After release, a new F read of a previously written location returns the stored value.
- Macro: G write of 0x5555 to 0x0030, then F read of 0x0030 → returns 0x5555 with `DCPU16_MRAM_GWR_EN`, returns the old value without it.
